line_fill_arbiter: RTL and testbench
====================================

Name: line_fill_arbiter

Overview:
- Shares one external memory read port between the per-core instruction/data caches of the multicore processor.
- Arbitrates cache-line refill requests round-robin and issues one line-aligned burst read per grant.
- Sequences WORDS_PER_LINE data beats back to the granted core, then signals completion.
- Sits between the per-core cache miss handlers and the memory interface.

Parameters:
- NUM_CORES, 4, number of requesting cores; must be ≥ 2.
- WORDS_PER_LINE, 8, words per cache line and beats per burst.
- DATA_SIZE, 32, word width in bits.
- ADDR_SIZE, 32, byte address width.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM_CORES  per-core refill request, level, bit k is core k.
- req_addr  input  NUM_CORES*ADDR_SIZE  per-core miss byte address; core k occupies bits [k*ADDR_SIZE +: ADDR_SIZE].
- grant  output  NUM_CORES  one-hot owner of the current refill; all zero when idle.
- fill_valid  output  1  the current beat on fill_data is valid for the granted core.
- fill_data  output  DATA_SIZE  refill word.
- fill_word  output  $clog2(WORDS_PER_LINE)  word index within the line of the current beat.
- fill_done  output  NUM_CORES  one-cycle pulse to the core whose line has completed.
- mem_req  output  1  burst read request to memory.
- mem_addr  output  ADDR_SIZE  line-aligned burst address.
- mem_ack  input  1  memory accepts the request in the current cycle.
- mem_rvalid  input  1  memory read beat valid.
- mem_rdata  input  DATA_SIZE  memory read beat data.

Behaviour:
- Reset (asynchronous, rst=1): FSM goes to IDLE. grant, fill_done, fill_valid, mem_req, mem_addr, fill_data and fill_word are all 0. The round-robin pointer and the beat counter are 0.
- States: IDLE, ISSUE, BURST, DONE.
- IDLE:
  - If any req bit is set, pick the first set bit at or after the pointer, searching upward with wrap-around.
  - Register the chosen one-hot into grant.
  - Register mem_addr = that core's req_addr with the low $clog2(WORDS_PER_LINE*DATA_SIZE/8) bits cleared (5 bits at defaults).
  - Go to ISSUE.
  - Arbitration takes one cycle; grant is visible the cycle after req is sampled.
- ISSUE:
  - mem_req=1 and mem_addr is held stable.
  - On mem_ack=1, deassert mem_req on the next edge and go to BURST.
  - mem_req stays high any number of cycles until acked.
  - mem_rvalid seen in ISSUE is ignored.
- BURST:
  - Each cycle with mem_rvalid=1 drives fill_valid=1, fill_data=mem_rdata and fill_word=counter combinationally (zero added latency), then increments the counter.
  - Beats are in-order, word 0 to WORDS_PER_LINE-1; gaps with mem_rvalid=0 are allowed.
  - On the last beat (counter = WORDS_PER_LINE-1 with mem_rvalid=1), reset the counter to 0 and go to DONE.
- DONE (exactly one cycle):
  - fill_done = grant.
  - Pointer = (granted index + 1) mod NUM_CORES.
  - grant clears on exit; return to IDLE.
  - A new arbitration can occur the cycle after DONE, so the minimum cycles between consecutive grants is WORDS_PER_LINE+3 with single-cycle ack and back-to-back beats.
- fill_valid is 0 outside BURST. fill_data and fill_word are don't-care when fill_valid=0 but driven to 0.
- Requesters hold req and req_addr until their fill_done. Deasserting req or changing req_addr after grant is ignored: the burst completes and fill_done still pulses.
- Simultaneous requests: the pointer breaks ties. Every continuously requesting core is granted within NUM_CORES grants (no starvation).
- A core asserting req in the same cycle as its own fill_done may be re-granted only if it is next in round-robin order among active requests.
- Reset mid-burst: immediate return to IDLE with all outputs cleared. Leftover memory beats after reset are ignored because mem_rvalid is not observed in IDLE.

Test Plan:
- Single request: req=4'b0010, req_addr[1]=0x0000_1234 → grant=0010 the next cycle; mem_req with mem_addr=0x0000_1220; after ack and 8 beats D0..D7, fill_word runs 0..7 with matching data; fill_done=0010 for one cycle; grant returns to 0.
- Round-robin fairness: req=4'b1111 held for 4 refills from reset → grant order 0001, 0010, 0100, 1000; the fifth grant is 0001.
- Backpressure and gaps: mem_ack held low for 5 cycles, then mem_rvalid toggling 1,0,1,... → mem_req stays high for 6 cycles total; exactly 8 fill_valid pulses; fill_done follows only after the 8th beat.
- Request dropped mid-burst: core 2 deasserts req after grant → all 8 beats are still delivered and fill_done=0100 still pulses; the pointer advances to 3.
- Reset mid-burst: assert rst after beat 3 → all outputs 0 that same cycle, the pointer is 0, and 4 more mem_rvalid beats produce no fill_valid.
- Stray beat in ISSUE: mem_rvalid=1 before mem_ack → no fill_valid and the counter stays 0.

Source files
------------

// File: rtl/line_fill_arbiter.sv
// rtl/line_fill_arbiter.sv - round-robin cache line refill arbiter sharing one memory read port
module line_fill_arbiter #(
    parameter int NUM_CORES      = 4,
    parameter int WORDS_PER_LINE = 8,
    parameter int DATA_SIZE      = 32,
    parameter int ADDR_SIZE      = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CORES-1:0]           req,
    input  logic [NUM_CORES*ADDR_SIZE-1:0] req_addr,
    output logic [NUM_CORES-1:0]           grant,
    output logic                           fill_valid,
    output logic [DATA_SIZE-1:0]           fill_data,
    output logic [$clog2(WORDS_PER_LINE)-1:0] fill_word,
    output logic [NUM_CORES-1:0]           fill_done,
    output logic                           mem_req,
    output logic [ADDR_SIZE-1:0]           mem_addr,
    input  logic                           mem_ack,
    input  logic                           mem_rvalid,
    input  logic [DATA_SIZE-1:0]           mem_rdata
);

    localparam int IDXW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int CNTW = $clog2(WORDS_PER_LINE);
    localparam int OFFW = $clog2(WORDS_PER_LINE * DATA_SIZE / 8);

    // Clears the byte offset within a line so bursts always start on a line boundary
    localparam logic [ADDR_SIZE-1:0] LINE_MASK = ~((ADDR_SIZE'(1) << OFFW) - ADDR_SIZE'(1));
    localparam logic [IDXW-1:0]      LAST_IDX  = IDXW'(NUM_CORES - 1);
    localparam logic [CNTW-1:0]      LAST_WORD = CNTW'(WORDS_PER_LINE - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]           r_state;
    logic [NUM_CORES-1:0] r_grant;
    logic [IDXW-1:0]      r_gidx;
    logic [IDXW-1:0]      r_ptr;
    logic [CNTW-1:0]      r_cnt;
    logic [ADDR_SIZE-1:0] r_mem_addr;

    logic [ADDR_SIZE-1:0] w_addr_arr [NUM_CORES];
    logic [IDXW-1:0]      w_sel_idx;
    logic                 w_any;
    logic                 w_beat;

    genvar g;
    generate
        for (g = 0; g < NUM_CORES; g++) begin : g_addr
            assign w_addr_arr[g] = req_addr[g*ADDR_SIZE +: ADDR_SIZE];
        end
    endgenerate

    // Round-robin search: scanning offsets from far to near lets the nearest
    // requester at or after the pointer overwrite any farther candidate.
    always_comb begin : p_search
        logic [IDXW:0] v_sum;
        v_sum     = '0;
        w_sel_idx = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            v_sum = {1'b0, r_ptr} + (IDXW+1)'(i);
            if (v_sum >= (IDXW+1)'(NUM_CORES)) begin
                v_sum = v_sum - (IDXW+1)'(NUM_CORES);
            end
            if (req[v_sum[IDXW-1:0]]) begin
                w_sel_idx = v_sum[IDXW-1:0];
            end
        end
    end

    assign w_any  = |req;
    assign w_beat = (r_state == ST_BURST) && mem_rvalid;

    // Refill sequencer: arbitrate, issue the burst, count beats, then retire the grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_gidx     <= '0;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_mem_addr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant    <= NUM_CORES'(1) << w_sel_idx;
                        r_gidx     <= w_sel_idx;
                        r_mem_addr <= w_addr_arr[w_sel_idx] & LINE_MASK;
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (mem_ack) begin
                        r_state <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (mem_rvalid) begin
                        if (r_cnt == LAST_WORD) begin
                            r_cnt   <= '0;
                            r_state <= ST_DONE;
                        end else begin
                            r_cnt <= r_cnt + CNTW'(1);
                        end
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_ptr   <= (r_gidx == LAST_IDX) ? '0 : r_gidx + IDXW'(1);
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant      = r_grant;
    assign mem_req    = (r_state == ST_ISSUE);
    assign mem_addr   = r_mem_addr;
    assign fill_done  = (r_state == ST_DONE) ? r_grant : '0;
    assign fill_valid = w_beat;
    assign fill_data  = w_beat ? mem_rdata : '0;
    assign fill_word  = w_beat ? r_cnt : '0;

endmodule

// File: tb/tb_line_fill_arbiter.sv
// tb/tb_line_fill_arbiter.sv - scoreboard bench for line_fill_arbiter
module tb_line_fill_arbiter;

    localparam int NC = 4;
    localparam int WL = 8;
    localparam int DS = 32;
    localparam int AS = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NC-1:0]     req;
    logic [NC*AS-1:0]  req_addr;
    logic [NC-1:0]     grant;
    logic              fill_valid;
    logic [DS-1:0]     fill_data;
    logic [2:0]        fill_word;
    logic [NC-1:0]     fill_done;
    logic              mem_req;
    logic [AS-1:0]     mem_addr;
    logic              mem_ack;
    logic              mem_rvalid;
    logic [DS-1:0]     mem_rdata;

    line_fill_arbiter #(.NUM_CORES(NC), .WORDS_PER_LINE(WL), .DATA_SIZE(DS), .ADDR_SIZE(AS)) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .grant(grant),
        .fill_valid(fill_valid), .fill_data(fill_data), .fill_word(fill_word),
        .fill_done(fill_done), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [NC-1:0] q_grant [$];
    logic [AS-1:0] q_gaddr [$];
    int            q_reqlen[$];
    int            q_bword [$];
    logic [DS-1:0] q_bdata [$];
    logic [NC-1:0] q_done  [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int core, input logic [AS-1:0] a);
        req_addr[core*AS +: AS] = a;
    endtask

    task automatic expect_refill(input logic [NC-1:0] g, input logic [AS-1:0] a, input int reqlen,
                                 input int nbeats, input logic [DS-1:0] dbase, input bit done);
        q_grant.push_back(g);
        q_gaddr.push_back(a);
        q_reqlen.push_back(reqlen);
        for (int w = 0; w < nbeats; w++) begin
            q_bword.push_back(w);
            q_bdata.push_back(dbase + DS'(w));
        end
        if (done) q_done.push_back(g);
    endtask

    // Plays the memory side; returns in the DONE cycle for full lines
    task automatic serve(input int ack_delay, input bit gaps, input bit stray, input bit drop_req,
                         input int nbeats, input logic [DS-1:0] dbase);
        int n;
        n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (mem_req !== 1'b1) begin
            $display("FAIL mem_req_timeout: got 0 expected 1");
            $fatal(1, "timeout");
        end
        if (drop_req) req = '0;
        for (int i = 0; i < ack_delay; i++) begin
            mem_rvalid = stray;
            mem_rdata  = 32'hBAD0_0000;
            tick();
        end
        mem_rvalid = 1'b0;
        mem_ack    = 1'b1;
        tick();
        mem_ack = 1'b0;
        for (int w = 0; w < nbeats; w++) begin
            if (gaps && w > 0) begin
                mem_rvalid = 1'b0;
                tick();
            end
            mem_rvalid = 1'b1;
            mem_rdata  = dbase + DS'(w);
            tick();
        end
        mem_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        mem_ack = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Monitor: pops expectations whenever the DUT presents an event
    initial begin
        logic [NC-1:0] prev_grant;
        int run;
        prev_grant = '0;
        run = 0;
        forever begin
            @(negedge clk);
            if (fill_valid) begin
                if (q_bword.size() == 0) chk("unexpected_beat", fill_valid, 0);
                else begin
                    chk("fill_word", fill_word, q_bword.pop_front());
                    chk("fill_data", fill_data, q_bdata.pop_front());
                end
            end
            if (fill_done != '0) begin
                if (q_done.size() == 0) chk("unexpected_done", fill_done, 0);
                else chk("fill_done", fill_done, q_done.pop_front());
            end
            if (grant != '0 && prev_grant == '0) begin
                if (q_grant.size() == 0) chk("unexpected_grant", grant, 0);
                else begin
                    chk("grant", grant, q_grant.pop_front());
                    chk("mem_addr", mem_addr, q_gaddr.pop_front());
                end
            end
            prev_grant = grant;
            if (mem_req) run++;
            else if (run > 0) begin
                if (q_reqlen.size() == 0) chk("unexpected_mem_req", run, 0);
                else chk("mem_req_cycles", run, q_reqlen.pop_front());
                run = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req_addr = '0;
        do_reset();

        // reset state
        rst = 1'b1;
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_fill_valid", fill_valid, 0);
        chk("rst_fill_done", fill_done, 0);
        tick();
        rst = 1'b0;

        // single request, core 1
        expect_refill(4'b0010, 32'h0000_1220, 1, 8, 32'hD000_0000, 1);
        set_addr(1, 32'h0000_1234);
        req = 4'b0010;
        tick();
        chk("grant_latency", grant, 4'b0010);
        serve(0, 0, 0, 0, 8, 32'hD000_0000);
        req = '0;
        tick();
        chk("grant_cleared", grant, 0);

        // round robin with all cores requesting from reset
        do_reset();
        for (int k = 0; k < NC; k++) set_addr(k, 32'h0000_1000 * (k + 1) + 32'h3C);
        for (int r = 0; r < 5; r++) begin
            expect_refill(NC'(1) << (r % NC), 32'h0000_1000 * ((r % NC) + 1) + 32'h20, 1, 8,
                          32'hA000_0000 + 32'h100 * r, 1);
        end
        req = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            serve(0, 0, 0, 0, 8, 32'hA000_0000 + 32'h100 * r);
            if (r == 4) req = '0;
            tick();
        end

        // backpressure on ack plus gapped beats
        do_reset();
        expect_refill(4'b0001, 32'h0000_ABC0, 6, 8, 32'hB000_0000, 1);
        set_addr(0, 32'h0000_ABCD);
        req = 4'b0001;
        serve(5, 1, 0, 0, 8, 32'hB000_0000);
        req = '0;
        tick();

        // request dropped after grant, then pointer must sit at core 3
        do_reset();
        set_addr(2, 32'h8000_0047);
        set_addr(3, 32'h9000_0011);
        expect_refill(4'b0100, 32'h8000_0040, 1, 8, 32'hC000_0000, 1);
        expect_refill(4'b1000, 32'h9000_0000, 1, 8, 32'hC100_0000, 1);
        req = 4'b0100;
        serve(0, 0, 0, 1, 8, 32'hC000_0000);
        req = 4'b1111;
        tick();
        serve(0, 0, 0, 0, 8, 32'hC100_0000);
        req = '0;
        tick();

        // reset in the middle of a burst
        do_reset();
        set_addr(0, 32'h0000_0040);
        set_addr(1, 32'h0000_1234);
        set_addr(2, 32'h0000_5678);
        expect_refill(4'b0010, 32'h0000_1220, 1, 8, 32'hE000_0000, 1);
        req = 4'b0010;
        serve(0, 0, 0, 0, 8, 32'hE000_0000);
        req = '0;
        tick();
        expect_refill(4'b0100, 32'h0000_5660, 1, 4, 32'hE100_0000, 0);
        req = 4'b0100;
        serve(0, 0, 0, 0, 4, 32'hE100_0000);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_0004;
        rst = 1'b1;
        #1;
        chk("midrst_grant", grant, 0);
        chk("midrst_fill_valid", fill_valid, 0);
        chk("midrst_fill_data", fill_data, 0);
        chk("midrst_fill_word", fill_word, 0);
        chk("midrst_mem_req", mem_req, 0);
        chk("midrst_mem_addr", mem_addr, 0);
        tick();
        rst = 1'b0;
        req = '0;
        for (int i = 0; i < 4; i++) tick();
        mem_rvalid = 1'b0;
        expect_refill(4'b0001, 32'h0000_0040, 1, 8, 32'hE200_0000, 1);
        req = 4'b1111;
        serve(0, 0, 0, 0, 8, 32'hE200_0000);
        req = '0;
        tick();

        // stray beats while the request is still unacknowledged
        do_reset();
        set_addr(0, 32'h0000_0FFF);
        expect_refill(4'b0001, 32'h0000_0FE0, 3, 8, 32'hF000_0000, 1);
        req = 4'b0001;
        serve(2, 0, 1, 0, 8, 32'hF000_0000);
        req = '0;
        tick();
        tick();
        tick();

        chk("left_beats", q_bword.size(), 0);
        chk("left_grants", q_grant.size(), 0);
        chk("left_done", q_done.size(), 0);
        chk("left_reqlen", q_reqlen.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
